// File: rtl/id_hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_ctl
// Brief    : Hazard controller beside the decode stage of a 5-stage MIPS
//            pipeline. Chooses RUN / STALL / FLUSH / FREEZE each cycle by
//            fixed priority and drives PC / IF-ID / ID-EX / hold controls
//            combinationally. Keeps a last-action register and saturating
//            stall, flush and freeze event counters.
// Revision : 1.0 - initial release
// ============================================================================
module id_hazard_ctl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IF_ID_instrout,
    input  logic             ID_EX_memread,
    input  logic [4:0]       ID_EX_rt,
    input  logic             EX_MEM_branch_taken,
    input  logic             mem_wait,
    input  logic             clr_stats,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_bubble,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    // Action encodings, also the visible value of the state output.
    localparam logic [1:0] c_st_run    = 2'd0;
    localparam logic [1:0] c_st_stall  = 2'd1;
    localparam logic [1:0] c_st_flush  = 2'd2;
    localparam logic [1:0] c_st_freeze = 2'd3;

    // Opcodes whose rt field is read as a source operand.
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_freeze_cnt;

    logic [5:0]       w_opcode;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic             w_rt_is_src;
    logic             w_load_use;
    logic             w_suppress;

    assign w_opcode = IF_ID_instrout[31:26];
    assign w_rs     = IF_ID_instrout[25:21];
    assign w_rt     = IF_ID_instrout[20:16];

    // rt is only read by R-type, beq, bne and sw; for loads/immediates it is a destination.
    assign w_rt_is_src = (w_opcode == c_op_rtype) || (w_opcode == c_op_beq) ||
                         (w_opcode == c_op_bne)   || (w_opcode == c_op_sw);

    // Register $0 never carries a real dependency.
    assign w_load_use = ID_EX_memread && (ID_EX_rt != 5'd0) &&
                        ((ID_EX_rt == w_rs) || (w_rt_is_src && (ID_EX_rt == w_rt)));

    // One cycle after a stall the load has moved on; after a flush ID holds a nop.
    assign w_suppress = (r_state == c_st_stall) || (r_state == c_st_flush);

    // Priority action select and Mealy control outputs; reset forces a safe bubble.
    always_comb begin
        w_next_state = c_st_run;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_bubble    = 1'b0;
        pipe_hold    = 1'b0;
        if (rst) begin
            w_next_state = c_st_run;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_bubble    = 1'b1;
            pipe_hold    = 1'b0;
        end else if (mem_wait) begin
            w_next_state = c_st_freeze;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            pipe_hold    = 1'b1;
        end else if (EX_MEM_branch_taken) begin
            w_next_state = c_st_flush;
            if_id_flush  = 1'b1;
            id_bubble    = 1'b1;
        end else if (w_load_use && !w_suppress) begin
            w_next_state = c_st_stall;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_bubble    = 1'b1;
        end
    end

    // Last-action register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Saturating event counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else if (clr_stats) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if ((w_next_state == c_st_stall) && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if ((w_next_state == c_st_flush) && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
            if ((w_next_state == c_st_freeze) && (r_freeze_cnt != c_cnt_max)) begin
                r_freeze_cnt <= r_freeze_cnt + c_cnt_one;
            end
        end
    end

    assign state      = r_state;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign freeze_cnt = r_freeze_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_hazard_ctl
// Brief    : Self-checking bench for id_hazard_ctl (CNT_W = 4). Expected
//            control vectors are queued as each cycle is driven and popped
//            when the outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_hazard_ctl;

    localparam int         CNT_W = 4;
    // Control vector order: {pc_write, if_id_write, if_id_flush, id_bubble, pipe_hold}
    localparam logic [4:0] c_run    = 5'b11000;
    localparam logic [4:0] c_stall  = 5'b00010;
    localparam logic [4:0] c_flush  = 5'b11110;
    localparam logic [4:0] c_freeze = 5'b00001;
    localparam logic [4:0] c_rst    = 5'b00010;

    localparam logic [31:0] c_add_9_8_10 = 32'h010A4820;
    localparam logic [31:0] c_addi_8_8   = 32'h21080001;
    localparam logic [31:0] c_lw_9_8     = 32'h8D090000;
    localparam logic [31:0] c_add_0_0_0  = 32'h00000020;
    localparam logic [31:0] c_nop        = 32'h00000000;

    logic             clk;
    logic             rst;
    logic [31:0]      IF_ID_instrout;
    logic             ID_EX_memread;
    logic [4:0]       ID_EX_rt;
    logic             EX_MEM_branch_taken;
    logic             mem_wait;
    logic             clr_stats;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_bubble;
    logic             pipe_hold;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] freeze_cnt;

    logic [4:0] exp_q[$];
    logic [4:0] r_obs;
    logic [4:0] r_exp;
    int         total;
    int         bad;

    id_hazard_ctl #(.CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .IF_ID_instrout     (IF_ID_instrout),
        .ID_EX_memread      (ID_EX_memread),
        .ID_EX_rt           (ID_EX_rt),
        .EX_MEM_branch_taken(EX_MEM_branch_taken),
        .mem_wait           (mem_wait),
        .clr_stats          (clr_stats),
        .pc_write           (pc_write),
        .if_id_write        (if_id_write),
        .if_id_flush        (if_id_flush),
        .id_bubble          (id_bubble),
        .pipe_hold          (pipe_hold),
        .state              (state),
        .stall_cnt          (stall_cnt),
        .flush_cnt          (flush_cnt),
        .freeze_cnt         (freeze_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs (just after a rising edge), queue the expected
    // controls and capture the DUT controls mid-cycle.
    task automatic drive(input logic [31:0] ins, input logic mr, input logic [4:0] rt,
                         input logic br, input logic mw, input logic clr,
                         input logic [4:0] exp);
        IF_ID_instrout      = ins;
        ID_EX_memread       = mr;
        ID_EX_rt            = rt;
        EX_MEM_branch_taken = br;
        mem_wait            = mw;
        clr_stats           = clr;
        exp_q.push_back(exp);
        #2;
        r_obs = {pc_write, if_id_write, if_id_flush, id_bubble, pipe_hold};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        IF_ID_instrout = c_nop; ID_EX_memread = 1'b0; ID_EX_rt = 5'd0;
        EX_MEM_branch_taken = 1'b0; mem_wait = 1'b0; clr_stats = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        IF_ID_instrout = c_add_9_8_10; ID_EX_memread = 1'b1; ID_EX_rt = 5'd8;
        EX_MEM_branch_taken = 1'b0; mem_wait = 1'b0; clr_stats = 1'b0;
        exp_q.push_back(c_rst);
        #2;
        r_obs = {pc_write, if_id_write, if_id_flush, id_bubble, pipe_hold};
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL reset_ctl got=%b want=%b", r_obs, r_exp); end
        total++;
        if ({state, stall_cnt, flush_cnt, freeze_cnt} !== '0) begin
            bad++; $display("FAIL reset_regs got state=%0d cnt=%0d/%0d/%0d want all 0",
                            state, stall_cnt, flush_cnt, freeze_cnt);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(c_add_9_8_10, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, c_stall);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL lu_stall got=%b want=%b", r_obs, r_exp); end
        tick();
        total++;
        if (state !== 2'd1 || stall_cnt !== 4'd1) begin
            bad++; $display("FAIL lu_state got state=%0d stall_cnt=%0d want 1/1", state, stall_cnt);
        end
        drive(c_add_9_8_10, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, c_run);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL lu_single got=%b want=%b", r_obs, r_exp); end
        tick();
        total++;
        if (state !== 2'd0 || stall_cnt !== 4'd1) begin
            bad++; $display("FAIL lu_after got state=%0d stall_cnt=%0d want 0/1", state, stall_cnt);
        end
    endtask

    task automatic test_rt_rule();
        do_reset();
        drive(c_addi_8_8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, c_stall);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL rt_rs_hit got=%b want=%b", r_obs, r_exp); end
        tick();
        drive(c_nop, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_run);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL rt_idle got=%b want=%b", r_obs, r_exp); end
        tick();
        drive(c_lw_9_8, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, c_run);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL rt_not_src got=%b want=%b", r_obs, r_exp); end
        tick();
        drive(c_add_0_0_0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, c_run);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL rt_zero got=%b want=%b", r_obs, r_exp); end
        tick();
        total++;
        if (stall_cnt !== 4'd1) begin bad++; $display("FAIL rt_cnt got=%0d want=1", stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(c_nop, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, c_flush);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL flush_ctl got=%b want=%b", r_obs, r_exp); end
        tick();
        total++;
        if (state !== 2'd2 || flush_cnt !== 4'd1) begin
            bad++; $display("FAIL flush_state got state=%0d flush_cnt=%0d want 2/1", state, flush_cnt);
        end
        drive(c_add_9_8_10, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, c_run);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL flush_nostall got=%b want=%b", r_obs, r_exp); end
        tick();
        total++;
        if (stall_cnt !== 4'd0 || state !== 2'd0) begin
            bad++; $display("FAIL flush_after got state=%0d stall_cnt=%0d want 0/0", state, stall_cnt);
        end
    endtask

    task automatic test_freeze_branch();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(c_nop, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, c_freeze);
            r_exp = exp_q.pop_front(); total++;
            if (r_obs !== r_exp) begin bad++; $display("FAIL frz_cyc%0d got=%b want=%b", i, r_obs, r_exp); end
            tick();
        end
        drive(c_nop, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, c_flush);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL frz_then_flush got=%b want=%b", r_obs, r_exp); end
        tick();
        total++;
        if (freeze_cnt !== 4'd3 || flush_cnt !== 4'd1) begin
            bad++; $display("FAIL frz_cnt got freeze=%0d flush=%0d want 3/1", freeze_cnt, flush_cnt);
        end
        drive(c_nop, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_run);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL frz_idle got=%b want=%b", r_obs, r_exp); end
        tick();
        // Freeze, branch and load-use all at once: freeze wins alone.
        drive(c_add_9_8_10, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, c_freeze);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL frz_all got=%b want=%b", r_obs, r_exp); end
        tick();
        total++;
        if (freeze_cnt !== 4'd4 || flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            bad++; $display("FAIL frz_all_cnt got %0d/%0d/%0d want 4/1/0", freeze_cnt, flush_cnt, stall_cnt);
        end
        // Pending load-use after a freeze stalls normally.
        drive(c_add_9_8_10, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, c_stall);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL frz_pending_lu got=%b want=%b", r_obs, r_exp); end
        tick();
        total++;
        if (stall_cnt !== 4'd1) begin bad++; $display("FAIL frz_lu_cnt got=%0d want=1", stall_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        // A held hit alternates STALL / RUN; 40 cycles give 20 stall events.
        for (int i = 0; i < 40; i++) begin
            drive(c_add_9_8_10, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, (i % 2 == 0) ? c_stall : c_run);
            r_exp = exp_q.pop_front(); total++;
            if (r_obs !== r_exp) begin bad++; $display("FAIL sat_cyc%0d got=%b want=%b", i, r_obs, r_exp); end
            tick();
        end
        total++;
        if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_value got=%0d want=15", stall_cnt); end
        drive(c_add_9_8_10, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, c_stall);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL clr_ctl got=%b want=%b", r_obs, r_exp); end
        tick();
        total++;
        if (stall_cnt !== 4'd0 || state !== 2'd1) begin
            bad++; $display("FAIL clr_value got stall_cnt=%0d state=%0d want 0/1", stall_cnt, state);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(c_nop, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, c_freeze);
            r_exp = exp_q.pop_front(); total++;
            if (r_obs !== r_exp) begin bad++; $display("FAIL ar_frz%0d got=%b want=%b", i, r_obs, r_exp); end
            tick();
        end
        total++;
        if (freeze_cnt !== 4'd2 || state !== 2'd3) begin
            bad++; $display("FAIL ar_pre got freeze=%0d state=%0d want 2/3", freeze_cnt, state);
        end
        #2;
        rst = 1'b1;
        exp_q.push_back(c_rst);
        #1;
        r_obs = {pc_write, if_id_write, if_id_flush, id_bubble, pipe_hold};
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL ar_ctl got=%b want=%b", r_obs, r_exp); end
        total++;
        if ({state, stall_cnt, flush_cnt, freeze_cnt} !== '0) begin
            bad++; $display("FAIL ar_regs got state=%0d cnt=%0d/%0d/%0d want all 0",
                            state, stall_cnt, flush_cnt, freeze_cnt);
        end
        tick();
        rst = 1'b0;
        drive(c_add_9_8_10, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, c_stall);
        r_exp = exp_q.pop_front(); total++;
        if (r_obs !== r_exp) begin bad++; $display("FAIL ar_from_run got=%b want=%b", r_obs, r_exp); end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        #1;
        test_reset();
        test_load_use();
        test_rt_rule();
        test_flush();
        test_freeze_branch();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
